bird_arbiter: RTL and testbench

Game-rule consumer of the pipe generator's outputs. Samples the pipe position, the gap row and the pass pulse, together with the bird row, and decides collisions, score and game state. Drives the `playing` enable back into the pipe generator and the bird physics, and provides BCD score and best-score digits to the display path.

---
 rtl/bird_arbiter.sv | 174 +++++++++++++++++
 tb/tb_bird_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bird_arbiter.sv
// bird_arbiter: game-rule block for the bird game.
// Takes the pipe generator outputs (pipe column, gap row, pass pulse) and the
// bird row. Decides collisions, keeps the BCD score and the best score, and
// runs the IDLE/PLAY/OVER game state with a restart lockout.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-high reset (also clears the best score)
//   i_start        one-cycle start/restart pulse
//   i_bird_y       bird row, 0 = top
//   i_pipe_x       pipe column
//   i_gap_y        top row of the pipe gap
//   i_pipe_passed  one-cycle pulse when the bird clears a pipe
//   o_playing      high in PLAY (enables pipe generator and bird physics)
//   o_game_over    high in OVER
//   o_crash        one-cycle pulse on PLAY -> OVER
//   o_score_*      BCD current score, saturating at 99
//   o_best_*       BCD best score since reset
//   o_new_best     high in OVER when the last game raised the best score
module bird_arbiter #(
    parameter int unsigned GAP_SIZE = 4,
    parameter int unsigned BIRD_X   = 12,
    parameter int unsigned GROUND_Y = 15,
    parameter int unsigned LOCKOUT  = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [3:0] i_bird_y,
    input  logic [3:0] i_pipe_x,
    input  logic [3:0] i_gap_y,
    input  logic       i_pipe_passed,
    output logic       o_playing,
    output logic       o_game_over,
    output logic       o_crash,
    output logic [3:0] o_score_tens,
    output logic [3:0] o_score_ones,
    output logic [3:0] o_best_tens,
    output logic [3:0] o_best_ones,
    output logic       o_new_best
);

    // Counter only ever holds LOCKOUT-1 down to 0.
    localparam int unsigned LOCK_W = (LOCKOUT > 2) ? $clog2(LOCKOUT) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t            r_state;
    logic [LOCK_W-1:0] r_lock;
    logic              r_playing;
    logic              r_game_over;
    logic              r_crash;
    logic              r_new_best;
    logic [3:0]        r_score_tens;
    logic [3:0]        r_score_ones;
    logic [3:0]        r_best_tens;
    logic [3:0]        r_best_ones;

    logic [4:0] w_gap_end;
    logic       w_at_pipe;
    logic       w_above_gap;
    logic       w_below_gap;
    logic       w_ground;
    logic       w_hit;
    logic [3:0] w_inc_tens;
    logic [3:0] w_inc_ones;
    logic       w_beats_best;

    // Collision detect; gap end is 5 bits wide so a gap near the bottom never wraps.
    assign w_gap_end   = {1'b0, i_gap_y} + 5'(GAP_SIZE);
    assign w_at_pipe   = (i_pipe_x == 4'(BIRD_X));
    assign w_above_gap = (i_bird_y < i_gap_y);
    assign w_below_gap = ({1'b0, i_bird_y} >= w_gap_end);
    assign w_ground    = (i_bird_y == 4'(GROUND_Y));
    assign w_hit       = (w_at_pipe && (w_above_gap || w_below_gap)) || w_ground;

    // Saturating two-digit BCD increment.
    always_comb begin
        w_inc_tens = r_score_tens;
        w_inc_ones = r_score_ones;
        if (r_score_ones == 4'd9) begin
            if (r_score_tens != 4'd9) begin
                w_inc_ones = 4'd0;
                w_inc_tens = r_score_tens + 4'd1;
            end
        end else begin
            w_inc_ones = r_score_ones + 4'd1;
        end
    end

    // Packed BCD digits compare correctly as a plain binary byte.
    assign w_beats_best = {r_score_tens, r_score_ones} > {r_best_tens, r_best_ones};

    // Game state machine with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_lock       <= '0;
            r_playing    <= 1'b0;
            r_game_over  <= 1'b0;
            r_crash      <= 1'b0;
            r_new_best   <= 1'b0;
            r_score_tens <= 4'd0;
            r_score_ones <= 4'd0;
            r_best_tens  <= 4'd0;
            r_best_ones  <= 4'd0;
        end else begin
            r_crash <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state      <= S_PLAY;
                        r_playing    <= 1'b1;
                        r_score_tens <= 4'd0;
                        r_score_ones <= 4'd0;
                    end
                end
                S_PLAY: begin
                    // A hit takes priority over a same-cycle pass.
                    if (w_hit) begin
                        r_state     <= S_OVER;
                        r_playing   <= 1'b0;
                        r_game_over <= 1'b1;
                        r_crash     <= 1'b1;
                        r_lock      <= LOCK_LOAD;
                        if (w_beats_best) begin
                            r_best_tens <= r_score_tens;
                            r_best_ones <= r_score_ones;
                            r_new_best  <= 1'b1;
                        end else begin
                            r_new_best  <= 1'b0;
                        end
                    end else if (i_pipe_passed) begin
                        r_score_tens <= w_inc_tens;
                        r_score_ones <= w_inc_ones;
                    end
                end
                S_OVER: begin
                    // Start is only honoured once the lockout has run out; earlier pulses drop.
                    if (r_lock != '0) begin
                        r_lock <= r_lock - LOCK_W'(1);
                    end else if (i_start) begin
                        r_state      <= S_PLAY;
                        r_playing    <= 1'b1;
                        r_game_over  <= 1'b0;
                        r_new_best   <= 1'b0;
                        r_score_tens <= 4'd0;
                        r_score_ones <= 4'd0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_playing   <= 1'b0;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign o_playing    = r_playing;
    assign o_game_over  = r_game_over;
    assign o_crash      = r_crash;
    assign o_new_best   = r_new_best;
    assign o_score_tens = r_score_tens;
    assign o_score_ones = r_score_ones;
    assign o_best_tens  = r_best_tens;
    assign o_best_ones  = r_best_ones;

endmodule

// File: tb/tb_bird_arbiter.sv
// tb_bird_arbiter: directed-vector bench for bird_arbiter with LOCKOUT = 8.
module tb_bird_arbiter;

    localparam int unsigned LOCK = 8;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] bird_y;
    logic [3:0] pipe_x;
    logic [3:0] gap_y;
    logic       pipe_passed;
    logic       playing;
    logic       game_over;
    logic       crash;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic [3:0] best_tens;
    logic [3:0] best_ones;
    logic       new_best;

    int total = 0;
    int bad   = 0;

    bird_arbiter #(
        .GAP_SIZE (4),
        .BIRD_X   (12),
        .GROUND_Y (15),
        .LOCKOUT  (LOCK)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_bird_y      (bird_y),
        .i_pipe_x      (pipe_x),
        .i_gap_y       (gap_y),
        .i_pipe_passed (pipe_passed),
        .o_playing     (playing),
        .o_game_over   (game_over),
        .o_crash       (crash),
        .o_score_tens  (score_tens),
        .o_score_ones  (score_ones),
        .o_best_tens   (best_tens),
        .o_best_ones   (best_ones),
        .o_new_best    (new_best)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One active edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pass();
        pipe_passed = 1'b1;
        tick();
        pipe_passed = 1'b0;
    endtask

    function automatic logic [7:0] score();
        return {score_tens, score_ones};
    endfunction

    function automatic logic [7:0] best();
        return {best_tens, best_ones};
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; pipe_passed = 1'b0;
        bird_y = 4'd8; gap_y = 4'd6; pipe_x = 4'd0;
        tick(); tick();
        reset = 1'b0;
        repeat (3) tick();

        // Reset values and idle behaviour.
        check("rst_playing",   32'(playing),   32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_crash",     32'(crash),     32'd0);
        check("rst_new_best",  32'(new_best),  32'd0);
        check("rst_score",     32'(score()),   32'h00);
        check("rst_best",      32'(best()),    32'h00);
        pass();
        check("idle_pass_score", 32'(score()), 32'h00);
        check("idle_playing",    32'(playing), 32'd0);

        // Game 1: twelve passes including the 09 -> 10 carry.
        pulse_start();
        check("g1_playing", 32'(playing), 32'd1);
        check("g1_score0",  32'(score()), 32'h00);
        for (int i = 1; i <= 12; i++) begin
            pass();
            if (i == 9)  check("g1_score09", 32'(score()), 32'h09);
            if (i == 10) check("g1_carry10", 32'(score()), 32'h10);
        end
        check("g1_score12", 32'(score()), 32'h12);
        check("g1_nocrash", 32'(crash),   32'd0);
        check("g1_playing_after", 32'(playing), 32'd1);

        // Start inside PLAY changes nothing.
        pulse_start();
        check("play_start_ign_score", 32'(score()), 32'h12);
        check("play_start_ign_play",  32'(playing), 32'd1);

        // Pipe hit below the gap (rows 6..9, bird at 10).
        pipe_x = 4'd12; bird_y = 4'd10;
        tick();                                   // entry edge N
        check("g1_crash",     32'(crash),     32'd1);
        check("g1_game_over", 32'(game_over), 32'd1);
        check("g1_play_off",  32'(playing),   32'd0);
        check("g1_best",      32'(best()),    32'h12);
        check("g1_new_best",  32'(new_best),  32'd1);
        pipe_x = 4'd0; bird_y = 4'd8;
        tick();                                   // after N+1
        check("g1_crash_once", 32'(crash), 32'd0);
        pass();                                   // edge N+2, ignored in OVER
        check("over_pass_ign", 32'(score()), 32'h12);
        repeat (4) tick();                        // after N+6
        pulse_start();                            // sampled at N+7: still locked
        check("lock_early_start", 32'(game_over), 32'd1);
        check("lock_early_play",  32'(playing),   32'd0);
        pulse_start();                            // sampled at N+8: accepted
        check("lock_ok_playing",  32'(playing),   32'd1);
        check("lock_ok_over_off", 32'(game_over), 32'd0);
        check("lock_ok_score",    32'(score()),   32'h00);
        check("lock_ok_new_best", 32'(new_best),  32'd0);

        // Game 2: score 5 then ground crash; best stays 12.
        repeat (5) pass();
        check("g2_score5", 32'(score()), 32'h05);
        bird_y = 4'd15;
        tick();
        bird_y = 4'd8;
        check("g2_crash",    32'(crash),    32'd1);
        check("g2_best",     32'(best()),   32'h12);
        check("g2_new_best", 32'(new_best), 32'd0);
        check("g2_score",    32'(score()),  32'h05);
        repeat (LOCK) tick();
        pulse_start();
        check("g3_playing", 32'(playing), 32'd1);

        // Game 3: saturation at 99.
        for (int i = 1; i <= 100; i++) begin
            pass();
            if (i == 99) check("g3_score99", 32'(score()), 32'h99);
        end
        check("g3_saturate", 32'(score()), 32'h99);
        bird_y = 4'd15;
        tick();
        bird_y = 4'd8;
        check("g3_best99",   32'(best()),   32'h99);
        check("g3_new_best", 32'(new_best), 32'd1);
        repeat (LOCK) tick();
        pulse_start();

        // Game 4: hit and pass together at score 3.
        repeat (3) pass();
        check("g4_score3", 32'(score()), 32'h03);
        pipe_x = 4'd12; bird_y = 4'd10; pipe_passed = 1'b1;
        tick();
        pipe_x = 4'd0; bird_y = 4'd8; pipe_passed = 1'b0;
        check("g4_hit_wins_score", 32'(score()),   32'h03);
        check("g4_crash",          32'(crash),     32'd1);
        check("g4_game_over",      32'(game_over), 32'd1);
        check("g4_new_best",       32'(new_best),  32'd0);
        check("g4_best",           32'(best()),    32'h99);
        repeat (LOCK) tick();
        pulse_start();

        // Game 5: gap boundaries; no-wrap gap end at gap_y = 12.
        pipe_x = 4'd12; gap_y = 4'd6; bird_y = 4'd6;
        tick();
        check("gap_top_row_safe", 32'(crash), 32'd0);
        bird_y = 4'd9;
        tick();
        check("gap_bot_row_safe", 32'(playing), 32'd1);
        gap_y = 4'd12; bird_y = 4'd14;
        tick();
        check("gap12_row14_safe", 32'(playing), 32'd1);
        bird_y = 4'd15;
        tick();
        check("gap12_ground_hit", 32'(crash), 32'd1);
        pipe_x = 4'd0; gap_y = 4'd6; bird_y = 4'd8;

        // Reset mid-lockout.
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_game_over", 32'(game_over), 32'd0);
        check("midrst_playing",   32'(playing),   32'd0);
        check("midrst_best",      32'(best()),    32'h00);
        check("midrst_score",     32'(score()),   32'h00);
        check("midrst_new_best",  32'(new_best),  32'd0);
        pulse_start();                            // IDLE accepts start immediately
        check("midrst_idle_start", 32'(playing), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
